// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register file sizes and dedicated register indices
package regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO        = 5'd0;
  localparam logic [REG_IDX_W-1:0] REG_S0          = 5'd16;
  localparam logic [REG_IDX_W-1:0] REG_OFFSET_BASE = 5'd24;
  localparam logic [REG_IDX_W-1:0] REG_FP          = 5'd30;

endpackage

// File: rtl/reg_array.sv
// rtl/reg_array.sv - 32-entry register storage with write port, offset-base clear and async reset
module reg_array
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_IDX_W-1:0]  reg1,
  input  logic [REG_IDX_W-1:0]  reg2,
  input  logic [REG_IDX_W-1:0]  reg_escrita,
  input  logic                  reg_write,
  input  logic [DATA_WIDTH-1:0] escreve_dado,
  input  logic                  clear_offset_base,
  output logic [DATA_WIDTH-1:0] dado1,
  output logic [DATA_WIDTH-1:0] dado2,
  output logic [DATA_WIDTH-1:0] fp,
  output logic [DATA_WIDTH-1:0] s0,
  output logic [DATA_WIDTH-1:0] offset_base
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  w_write_en;

  assign w_write_en = reg_write && (reg_escrita != REG_ZERO);

  // r0 is only ever loaded by reset, so it stays zero without a read-side mux.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_write_en) begin
        r_regs[reg_escrita] <= escreve_dado;
      end
      if (clear_offset_base) begin
        r_regs[REG_OFFSET_BASE] <= '0;
      end
    end
  end

  assign dado1       = r_regs[reg1];
  assign dado2       = r_regs[reg2];
  assign fp          = r_regs[REG_FP];
  assign s0          = r_regs[REG_S0];
  assign offset_base = r_regs[REG_OFFSET_BASE];

endmodule

// File: rtl/regfile_branch_unit.sv
// rtl/regfile_branch_unit.sv - register file plus branch decision and next-PC target adder
module regfile_branch_unit
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int INSTR_ADDR_WIDTH = 13
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [REG_IDX_W-1:0]        reg1,
  input  logic [REG_IDX_W-1:0]        reg2,
  input  logic [REG_IDX_W-1:0]        reg_escrita,
  input  logic                        reg_write,
  input  logic [DATA_WIDTH-1:0]       escreve_dado,
  input  logic                        clear_offset_base,
  output logic [DATA_WIDTH-1:0]       dado1,
  output logic [DATA_WIDTH-1:0]       dado2,
  output logic [DATA_WIDTH-1:0]       fp,
  output logic [DATA_WIDTH-1:0]       s0,
  output logic [DATA_WIDTH-1:0]       offset_base,
  input  logic                        control_beq,
  input  logic                        control_bne,
  input  logic                        zero,
  output logic                        control_branch,
  input  logic [DATA_WIDTH-1:0]       imediato,
  input  logic [INSTR_ADDR_WIDTH-1:0] pc_atual,
  output logic [INSTR_ADDR_WIDTH-1:0] novo_endereco
);

  logic                        w_branch;
  logic [INSTR_ADDR_WIDTH-1:0] w_pc_inc;
  logic [INSTR_ADDR_WIDTH-1:0] w_offset;
  logic                        w_unused_imm_hi;

  reg_array #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reg_array (
    .clock             (clock),
    .reset_n           (reset_n),
    .reg1              (reg1),
    .reg2              (reg2),
    .reg_escrita       (reg_escrita),
    .reg_write         (reg_write),
    .escreve_dado      (escreve_dado),
    .clear_offset_base (clear_offset_base),
    .dado1             (dado1),
    .dado2             (dado2),
    .fp                (fp),
    .s0                (s0),
    .offset_base       (offset_base)
  );

  assign w_branch       = (control_beq && zero) || (control_bne && !zero);
  assign control_branch = w_branch;

  // Target wraps modulo the PC width; immediate bits above the PC width are dropped.
  assign w_pc_inc        = pc_atual + INSTR_ADDR_WIDTH'(1);
  assign w_offset        = w_branch ? imediato[INSTR_ADDR_WIDTH-1:0] : '0;
  assign novo_endereco   = w_pc_inc + w_offset;
  assign w_unused_imm_hi = ^imediato[DATA_WIDTH-1:INSTR_ADDR_WIDTH];

endmodule

// File: tb/tb_regfile_branch_unit.sv
// tb/tb_regfile_branch_unit.sv - scoreboard bench for regfile_branch_unit against a behavioural model
module tb_regfile_branch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  reg1, reg2, reg_escrita;
  logic        reg_write;
  logic [31:0] escreve_dado;
  logic        clear_offset_base;
  logic [31:0] dado1, dado2, fp, s0, offset_base;
  logic        control_beq, control_bne, zero;
  logic        control_branch;
  logic [31:0] imediato;
  logic [12:0] pc_atual;
  logic [12:0] novo_endereco;

  typedef struct {
    string       tag;
    logic [31:0] d1, d2, fp, s0, ob;
    logic        br;
    logic [12:0] nxt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  regfile_branch_unit #(.DATA_WIDTH(32), .INSTR_ADDR_WIDTH(13)) dut (
    .clock(clock), .reset_n(reset_n), .reg1(reg1), .reg2(reg2),
    .reg_escrita(reg_escrita), .reg_write(reg_write), .escreve_dado(escreve_dado),
    .clear_offset_base(clear_offset_base), .dado1(dado1), .dado2(dado2), .fp(fp),
    .s0(s0), .offset_base(offset_base), .control_beq(control_beq),
    .control_bne(control_bne), .zero(zero), .control_branch(control_branch),
    .imediato(imediato), .pc_atual(pc_atual), .novo_endereco(novo_endereco)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=0x%0h required=0x%0h", tag, what, act, exp);
  endtask

  // Monitor: each falling edge, compare the DUT against the oldest pending expectation.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "dado1", dado1, e.d1);
      chk(e.tag, "dado2", dado2, e.d2);
      chk(e.tag, "fp", fp, e.fp);
      chk(e.tag, "s0", s0, e.s0);
      chk(e.tag, "offset_base", offset_base, e.ob);
      chk(e.tag, "control_branch", {31'b0, control_branch}, {31'b0, e.br});
      chk(e.tag, "novo_endereco", {19'b0, novo_endereco}, {19'b0, e.nxt});
    end
  end

  function automatic exp_t predict(input string tag);
    exp_t        e;
    int unsigned t;
    e.tag = tag;
    e.d1  = reset_n ? model[reg1] : 32'h0;
    e.d2  = reset_n ? model[reg2] : 32'h0;
    e.fp  = reset_n ? model[30] : 32'h0;
    e.s0  = reset_n ? model[16] : 32'h0;
    e.ob  = reset_n ? model[24] : 32'h0;
    e.br  = (control_beq && zero) || (control_bne && !zero);
    t     = int'(pc_atual) + 1 + (e.br ? (imediato % 8192) : 0);
    e.nxt = 13'(t % 8192);
    return e;
  endfunction

  // Issue one cycle: predict, wait for the check, then apply the write semantics to the model.
  task automatic cycle(input string tag);
    exp_q.push_back(predict(tag));
    @(negedge clock);
    @(posedge clock);
    if (reset_n) begin
      if (reg_write && reg_escrita != 0) model[reg_escrita] = escreve_dado;
      if (clear_offset_base) model[24] = 32'h0;
    end
    #1;
  endtask

  task automatic set_wr(input logic we, input logic [4:0] idx, input logic [31:0] d, input logic clr);
    reg_write = we; reg_escrita = idx; escreve_dado = d; clear_offset_base = clr;
  endtask

  task automatic set_br(input logic beq, input logic bne, input logic z, input logic [12:0] pc, input logic [31:0] imm);
    control_beq = beq; control_bne = bne; zero = z; pc_atual = pc; imediato = imm;
  endtask

  // Async reset pulse between rising edges, with a write pending to confirm it is discarded.
  task automatic reset_pulse(input string tag);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_q.push_back(predict(tag));
    @(negedge clock);
    #1;
    reg_write = 1'b0; clear_offset_base = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    reset_n = 1'b0;
    reg1 = 0; reg2 = 0;
    set_wr(0, 0, 0, 0);
    set_br(0, 0, 0, 13'd0, 32'd0);
    @(posedge clock); #1;
    cycle("reset");
    reset_n = 1'b1;

    set_wr(1, 5'd5, 32'h1234, 0); reg1 = 5; cycle("wr_r5_old");
    set_wr(1, 5'd0, 32'hFFFF, 0); cycle("rd_r5");
    reg1 = 0; set_wr(0, 0, 0, 0); cycle("rd_r0");

    set_wr(1, 5'd24, 32'd7, 0); cycle("wr_r24");
    set_wr(1, 5'd24, 32'd9, 1); cycle("ob_7");
    set_wr(1, 5'd3, 32'hABCD, 1); reg2 = 3; cycle("ob_clear");
    set_wr(0, 0, 0, 0); cycle("clr_other_wr");

    set_wr(1, 5'd16, 32'hCAFE0016, 0); cycle("wr_s0");
    set_wr(1, 5'd30, 32'hBEEF0030, 0); cycle("wr_fp");
    set_wr(1, 5'd24, 32'h55, 0); reg1 = 16; reg2 = 30; cycle("s0_fp");
    set_wr(1, 5'd7, 32'h77, 0); reset_pulse("async_rst");
    cycle("post_rst");

    set_br(1, 0, 1, 13'd10, 32'd5);      cycle("beq_z1");
    set_br(1, 0, 0, 13'd10, 32'd5);      cycle("beq_z0");
    set_br(0, 1, 0, 13'd10, 32'd5);      cycle("bne_z0");
    set_br(0, 1, 1, 13'd10, 32'd5);      cycle("bne_z1");
    set_br(1, 1, 0, 13'd10, 32'd5);      cycle("both_z0");
    set_br(1, 1, 1, 13'd10, 32'd5);      cycle("both_z1");
    set_br(1, 0, 1, 13'd10, 32'h1FFD);   cycle("back_branch");
    set_br(1, 0, 1, 13'd10, 32'hFFFF0003); cycle("imm_hi_drop");
    set_br(0, 0, 0, 13'h1FFF, 32'd5);    cycle("pc_wrap");

    for (int n = 0; n < 400; n++) begin
      logic [4:0] idx;
      idx = ($urandom_range(0, 3) == 0) ? 5'(($urandom_range(0, 3) == 0) ? 0 :
            ($urandom_range(0, 2) == 0) ? 16 : ($urandom_range(0, 1) == 0) ? 24 : 30)
            : 5'($urandom_range(0, 31));
      set_wr(1'($urandom_range(0, 1)), idx, $urandom, 1'($urandom_range(0, 7) == 0));
      reg1 = 5'($urandom_range(0, 31));
      reg2 = 5'($urandom_range(0, 31));
      set_br(1'($urandom), 1'($urandom), 1'($urandom), 13'($urandom), $urandom);
      if ($urandom_range(0, 99) == 0) reset_pulse("rand_rst");
      else cycle("rand");
    end

    set_wr(0, 0, 0, 0);
    repeat (3) @(negedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
